// File: rtl/sram_dist_pkg.sv
// Shared types for the SRAM distributor: port FSM states, scan candidate, ranking.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a. Optional macro DEST_AFFINITY_EN selects page_amount-first ranking.
package sram_dist_pkg;

    // Build configuration; the module parameters default to these values.
    localparam int DEF_NUM_PORTS = 16;
    localparam int DEF_NUM_SRAMS = 32;
    localparam int DEF_SPACE_W   = 11;
    localparam int DEF_DEST_W    = 4;
    localparam int DEF_LEN_W     = 9;
    localparam int DEF_MIN_SPACE = 512;

    localparam int SRAM_IDX_W = $clog2(DEF_NUM_SRAMS);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        GRANT,
        HOLD
    } port_state_t;

    typedef struct packed {
        logic                   vld;
        logic [SRAM_IDX_W-1:0]  idx;
        logic [DEF_SPACE_W-1:0] pages;
        logic [DEF_SPACE_W-1:0] space;
    } cand_t;

    // True when a must replace b. Strictly-better only, so the earliest probed SRAM keeps ties.
    function automatic logic better(input cand_t a, input cand_t b);
        logic r;
        if (!a.vld) begin
            r = 1'b0;
        end else if (!b.vld) begin
            r = 1'b1;
`ifdef DEST_AFFINITY_EN
        end else if (a.pages != b.pages) begin
            r = (a.pages > b.pages);
`endif
        end else begin
            r = (a.space > b.space);
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_distributor_port_fsm.sv
// Per-port scanner: walks every SRAM once per scan, keeps the best candidate, requests a grant.
// Latency: grant_vld NUM_SRAMS+2 cycles after req_vld (NUM_SRAMS+1 without DEST_AFFINITY_EN).
// Backpressure: a lost grant or an empty scan simply restarts the scan; req_vld is only taken in IDLE.
module dist_port_fsm
    import sram_dist_pkg::*;
#(
    parameter int NUM_SRAMS = DEF_NUM_SRAMS,
    parameter int SPACE_W   = DEF_SPACE_W,
    parameter int DEST_W    = DEF_DEST_W,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int PORT_ID   = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [SRAM_IDX_W-1:0]             step,
    input  logic                              req_vld,
    input  logic [DEST_W-1:0]                 req_dest,
    input  logic [LEN_W-1:0]                  req_len,
    input  logic                              release_req,
    input  logic [NUM_SRAMS-1:0]              locked,
    input  logic [NUM_SRAMS-1:0][SPACE_W-1:0] free_space,
    input  logic [NUM_SRAMS-1:0][SPACE_W-1:0] page_amount,
    input  logic                              grant_ok,
    output logic                              probe_vld,
    output logic [SRAM_IDX_W-1:0]             probe_idx,
    output logic [DEST_W-1:0]                 probe_dest,
    output logic                              grant_req,
    output logic [SRAM_IDX_W-1:0]             grant_idx,
    output logic                              rel_vld,
    output logic                              grant_vld,
    output logic [SRAM_IDX_W-1:0]             grant_sram
);
    localparam int CNT_W = SRAM_IDX_W + 1;
`ifdef DEST_AFFINITY_EN
    localparam int LAST_CNT = NUM_SRAMS;
`else
    localparam int LAST_CNT = NUM_SRAMS - 1;
`endif

    port_state_t           state;
    logic [DEST_W-1:0]     dest_q;
    logic [LEN_W-1:0]      len_q;
    logic [CNT_W-1:0]      cnt;
    cand_t                 cand;
    cand_t                 new_cand;
    cand_t                 cand_next;
    logic [CNT_W-1:0]      probe_sum;
    logic [SRAM_IDX_W-1:0] eval_idx;
    logic                  eval_act;
    logic                  eligible;

    // Staggered mapping: port p looks at SRAM (step + p) mod NUM_SRAMS.
    assign probe_sum  = {1'b0, step} + CNT_W'(PORT_ID);
    assign probe_idx  = (probe_sum >= CNT_W'(NUM_SRAMS)) ? SRAM_IDX_W'(probe_sum - CNT_W'(NUM_SRAMS))
                                                         : probe_sum[SRAM_IDX_W-1:0];
    assign probe_vld  = (state == SCAN) && (cnt < CNT_W'(NUM_SRAMS));
    assign probe_dest = dest_q;
    assign grant_req  = (state == GRANT);
    assign grant_idx  = cand.idx;
    assign rel_vld    = (state == HOLD) && release_req;

`ifdef DEST_AFFINITY_EN
    logic [SRAM_IDX_W-1:0] eval_idx_q;
    logic                  eval_vld_q;
    // page_amount answers one cycle after the probe, so evaluation trails probing by one cycle.
    assign eval_idx = eval_idx_q;
    assign eval_act = (state == SCAN) && eval_vld_q;
`else
    logic unused_pages;
    assign unused_pages = ^page_amount;
    assign eval_idx = probe_idx;
    assign eval_act = probe_vld;
`endif

    // Candidate update: eligible SRAMs replace the held candidate only when strictly better.
    always_comb begin
        new_cand       = '0;
        new_cand.vld   = 1'b1;
        new_cand.idx   = eval_idx;
        new_cand.space = free_space[eval_idx];
`ifdef DEST_AFFINITY_EN
        new_cand.pages = page_amount[eval_idx];
`endif
        eligible  = eval_act && !locked[eval_idx] && (SPACE_W'(len_q) <= free_space[eval_idx]);
        cand_next = (eligible && better(new_cand, cand)) ? new_cand : cand;
    end

    // Port FSM: capture request, scan, contend for the grant, hold the lock until release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dest_q     <= '0;
            len_q      <= '0;
            cnt        <= '0;
            cand       <= '0;
            grant_vld  <= 1'b0;
            grant_sram <= '0;
`ifdef DEST_AFFINITY_EN
            eval_idx_q <= '0;
            eval_vld_q <= 1'b0;
`endif
        end else begin
            grant_vld <= 1'b0;
`ifdef DEST_AFFINITY_EN
            eval_idx_q <= probe_idx;
            eval_vld_q <= probe_vld;
`endif
            case (state)
                IDLE: if (req_vld) begin
                    dest_q <= req_dest;
                    len_q  <= req_len;
                    cand   <= '0;
                    cnt    <= '0;
                    state  <= SCAN;
                end
                SCAN: if (cnt == CNT_W'(LAST_CNT)) begin
                    cnt <= '0;
                    if (cand_next.vld) begin
                        cand  <= cand_next;
                        state <= GRANT;
                    end else begin
                        cand <= '0;
                    end
                end else begin
                    cnt  <= cnt + 1'b1;
                    cand <= cand_next;
                end
                GRANT: if (grant_ok) begin
                    grant_vld  <= 1'b1;
                    grant_sram <= cand.idx;
                    state      <= HOLD;
                end else begin
                    cand  <= '0;
                    cnt   <= '0;
                    state <= SCAN;
                end
                HOLD: if (release_req) begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sram_distributor.sv
// SRAM selection engine: step counter, lock vector, grant arbitration and full flag over NUM_PORTS scanners.
// Latency: grant NUM_SRAMS+2 cycles after request (NUM_SRAMS+1 without DEST_AFFINITY_EN); full is 1 cycle.
// Backpressure: none; lower-index ports win same-cycle grant conflicts, losers rescan. Macro: DEST_AFFINITY_EN.
module sram_distributor
    import sram_dist_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int NUM_SRAMS = DEF_NUM_SRAMS,
    parameter int SPACE_W   = DEF_SPACE_W,
    parameter int DEST_W    = DEF_DEST_W,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int MIN_SPACE = DEF_MIN_SPACE
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS-1:0]                 req_vld,
    input  logic [NUM_PORTS-1:0][DEST_W-1:0]     req_dest,
    input  logic [NUM_PORTS-1:0][LEN_W-1:0]      req_len,
    input  logic [NUM_PORTS-1:0]                 release_req,
    input  logic [NUM_SRAMS-1:0][SPACE_W-1:0]    free_space,
    input  logic [NUM_SRAMS-1:0][SPACE_W-1:0]    page_amount,
    output logic [NUM_SRAMS-1:0][DEST_W-1:0]     probe_port,
    output logic [NUM_PORTS-1:0]                 grant_vld,
    output logic [NUM_PORTS-1:0][SRAM_IDX_W-1:0] grant_sram,
    output logic [NUM_SRAMS-1:0]                 locked,
    output logic [NUM_PORTS-1:0]                 full
);
    logic [SRAM_IDX_W-1:0]                 step;
    logic [NUM_PORTS-1:0]                  probe_vld;
    logic [NUM_PORTS-1:0]                  grant_req;
    logic [NUM_PORTS-1:0]                  grant_ok;
    logic [NUM_PORTS-1:0]                  rel_vld;
    logic [NUM_PORTS-1:0][SRAM_IDX_W-1:0]  probe_idx;
    logic [NUM_PORTS-1:0][SRAM_IDX_W-1:0]  grant_idx;
    logic [NUM_PORTS-1:0][DEST_W-1:0]      probe_dest;
    logic [NUM_SRAMS-1:0]                  lock_set;
    logic [NUM_SRAMS-1:0]                  lock_clr;
    logic [NUM_SRAMS-1:0]                  avail;
    logic                                  full_q;

    // Free-running step counter shared by all scanners.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= '0;
        end else if (step == SRAM_IDX_W'(NUM_SRAMS - 1)) begin
            step <= '0;
        end else begin
            step <= step + 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        dist_port_fsm #(
            .NUM_SRAMS (NUM_SRAMS),
            .SPACE_W   (SPACE_W),
            .DEST_W    (DEST_W),
            .LEN_W     (LEN_W),
            .PORT_ID   (p)
        ) u_port (
            .clk         (clk),
            .rst         (rst),
            .step        (step),
            .req_vld     (req_vld[p]),
            .req_dest    (req_dest[p]),
            .req_len     (req_len[p]),
            .release_req (release_req[p]),
            .locked      (locked),
            .free_space  (free_space),
            .page_amount (page_amount),
            .grant_ok    (grant_ok[p]),
            .probe_vld   (probe_vld[p]),
            .probe_idx   (probe_idx[p]),
            .probe_dest  (probe_dest[p]),
            .grant_req   (grant_req[p]),
            .grant_idx   (grant_idx[p]),
            .rel_vld     (rel_vld[p]),
            .grant_vld   (grant_vld[p]),
            .grant_sram  (grant_sram[p])
        );
    end

    // Grant arbitration against the pre-release lock; the lowest-index port claims a contested SRAM.
    always_comb begin
        grant_ok = '0;
        lock_set = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_req[p] && !locked[grant_idx[p]] && !lock_set[grant_idx[p]]) begin
                grant_ok[p]            = 1'b1;
                lock_set[grant_idx[p]] = 1'b1;
            end
        end
    end

    // Releases from holding ports, and per-SRAM availability for the full flag.
    always_comb begin
        lock_clr = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rel_vld[p]) begin
                lock_clr[grant_sram[p]] = 1'b1;
            end
        end
        for (int s = 0; s < NUM_SRAMS; s++) begin
            avail[s] = !locked[s] && (free_space[s] >= SPACE_W'(MIN_SPACE));
        end
    end

    // Lock vector and registered full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked <= '0;
            full_q <= 1'b0;
        end else begin
            locked <= (locked & ~lock_clr) | lock_set;
            full_q <= ~|avail;
        end
    end

    assign full = {NUM_PORTS{full_q}};

`ifdef DEST_AFFINITY_EN
    logic [NUM_SRAMS-1:0][DEST_W-1:0] probe_next;

    // Route each scanning port's destination to the SRAM it probes this cycle.
    always_comb begin
        probe_next = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (probe_vld[p]) begin
                probe_next[probe_idx[p]] = probe_dest[p];
            end
        end
    end

    // Registered probe destination towards the per-SRAM state blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            probe_port <= '0;
        end else begin
            probe_port <= probe_next;
        end
    end
`else
    logic unused_probe;
    assign unused_probe = ^{probe_vld, probe_idx, probe_dest};
    assign probe_port   = '0;
`endif

endmodule

// File: tb/tb_sram_distributor.sv
// Randomized self-checking bench for sram_distributor against a probe-order reference model.
// Latency: checks exact grant latency for uncontended requests.
// Backpressure: exercises contention, size-limited rescans, full flag and reset mid-hold.
module tb_sram_distributor;
    localparam int NP = 16;
    localparam int NS = 32;
    localparam int SW = 11;
    localparam int DW = 4;
    localparam int LW = 9;
    localparam int IW = 5;
`ifdef DEST_AFFINITY_EN
    localparam bit AFF = 1'b1;
    localparam int LAT = NS + 2;
`else
    localparam bit AFF = 1'b0;
    localparam int LAT = NS + 1;
`endif

    logic                   clk;
    logic                   rst;
    logic [NP-1:0]          req_vld;
    logic [NP-1:0][DW-1:0]  req_dest;
    logic [NP-1:0][LW-1:0]  req_len;
    logic [NP-1:0]          release_req;
    logic [NS-1:0][SW-1:0]  free_space;
    logic [NS-1:0][SW-1:0]  page_amount;
    logic [NS-1:0][DW-1:0]  probe_port;
    logic [NP-1:0]          grant_vld;
    logic [NP-1:0][IW-1:0]  grant_sram;
    logic [NS-1:0]          locked;
    logic [NP-1:0]          full;

    int            n_chk  = 0;
    int            n_fail = 0;
    int            fs_m[NS];
    int            pa_m[NS];
    logic [NS-1:0] lk_m;
    int            k_m;

    sram_distributor dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_dest    (req_dest),
        .req_len     (req_len),
        .release_req (release_req),
        .free_space  (free_space),
        .page_amount (page_amount),
        .probe_port  (probe_port),
        .grant_vld   (grant_vld),
        .grant_sram  (grant_sram),
        .locked      (locked),
        .full        (full)
    );

    always #5 clk = ~clk;

    // Reference step counter: resets to 0 and wraps after NS-1.
    always @(posedge clk or posedge rst) begin
        if (rst) k_m <= 0;
        else     k_m <= (k_m + 1) % NS;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Best eligible SRAM for port p whose first probe uses step k0, walking the probe order.
    function automatic int exp_sram(input int p, input int k0, input int len, input logic [NS-1:0] lk);
        int best;
        int s;
        best = -1;
        for (int i = 0; i < NS; i++) begin
            s = (k0 + p + i) % NS;
            if (!lk[s] && fs_m[s] >= len) begin
                if (best < 0)
                    best = s;
                else if (AFF && pa_m[s] != pa_m[best]) begin
                    if (pa_m[s] > pa_m[best]) best = s;
                end else if (fs_m[s] > fs_m[best])
                    best = s;
            end
        end
        return best;
    endfunction

    function automatic logic [NP-1:0] exp_full();
        logic any;
        any = 1'b0;
        for (int s = 0; s < NS; s++)
            if (!lk_m[s] && fs_m[s] >= 512) any = 1'b1;
        return any ? '0 : '1;
    endfunction

    function automatic int count_probe();
        int n;
        n = 0;
        for (int s = 0; s < NS; s++)
            if (probe_port[s] != '0) n++;
        return n;
    endfunction

    task automatic apply_mem();
        for (int s = 0; s < NS; s++) begin
            free_space[s]  = SW'(fs_m[s]);
            page_amount[s] = SW'(pa_m[s]);
        end
    endtask

    task automatic set_all(input int fs, input int pa);
        for (int s = 0; s < NS; s++) begin
            fs_m[s] = fs;
            pa_m[s] = pa;
        end
    endtask

    // Present a request on every port in mask for one edge; k0 is the step of the first scan cycle.
    task automatic do_req(input logic [NP-1:0] mask, input int dest, input int len, output int k0);
        @(negedge clk);
        apply_mem();
        for (int p = 0; p < NP; p++) begin
            if (mask[p]) begin
                req_vld[p]  = 1'b1;
                req_dest[p] = DW'(dest);
                req_len[p]  = LW'(len);
            end
        end
        @(posedge clk); #1;
        req_vld = '0;
        k0 = k_m;
    endtask

    // Count edges since the request edge until grant_vld[p]; -1 when the budget runs out.
    task automatic wait_grant(input int p, input int budget, input int start, output int lat);
        lat = start;
        while (!grant_vld[p] && lat < budget) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!grant_vld[p]) lat = -1;
    endtask

    task automatic pulse_release(input logic [NP-1:0] mask);
        @(negedge clk);
        release_req = mask;
        @(posedge clk); #1;
        release_req = '0;
    endtask

    task automatic run_single(input string nm, input int p, input int dest, input int len);
        int k0, lat, es;
        logic [NP-1:0] m;
        m = '0;
        m[p] = 1'b1;
        do_req(m, dest, len, k0);
        es = exp_sram(p, k0, len, lk_m);
        @(posedge clk); #1;
        check({nm, "_probe_cnt"}, count_probe(), AFF ? 1 : 0);
        check({nm, "_probe_dest"}, probe_port[(k0 + p) % NS], AFF ? dest : 0);
        wait_grant(p, LAT + 4, 1, lat);
        check({nm, "_lat"}, lat, LAT);
        check({nm, "_sram"}, grant_sram[p], es);
        if (es >= 0) lk_m[es] = 1'b1;
        check({nm, "_locked"}, locked, lk_m);
        @(posedge clk); #1;
        check({nm, "_pulse"}, grant_vld[p], 0);
        check({nm, "_full"}, full, exp_full());
        pulse_release(m);
        if (es >= 0) lk_m[es] = 1'b0;
        check({nm, "_unlock"}, locked, lk_m);
    endtask

    initial begin
        int k0, lat, es, u, len;
        clk = 1'b0; rst = 1'b1;
        req_vld = '0; req_dest = '0; req_len = '0; release_req = '0;
        set_all(0, 0);
        lk_m = '0;
        apply_mem();
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant_vld", grant_vld, 0);
        check("rst_locked", locked, 0);
        check("rst_full", full, 0);
        check("rst_gsram_nz", grant_sram != '0, 0);
        check("rst_probe_cnt", count_probe(), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single request, SRAM 7 has the most pages for this destination.
        set_all(2047, 0);
        pa_m[7] = 20;
        run_single("single", 3, 5, 10);

        // Equal page_amount everywhere: most free space wins.
        set_all(600, 5);
        fs_m[12] = 900;
        run_single("space", 6, 2, 100);

        // Randomized trials with deliberately coarse values to produce ties.
        for (int t = 0; t < 8; t++) begin
            len = $urandom_range(1, 511);
            for (int s = 0; s < NS; s++) begin
                fs_m[s] = $urandom_range(0, 4) * 500;
                pa_m[s] = $urandom_range(0, 3) * 10;
            end
            fs_m[$urandom_range(0, NS - 1)] = 2047;
            run_single($sformatf("rand%0d", t), $urandom_range(0, NP - 1), $urandom_range(1, 15), len);
        end

        // Contention: ports 0 and 1 both want the only eligible SRAM.
        set_all(0, 0);
        fs_m[4] = 2047;
        do_req(16'h0003, 9, 10, k0);
        wait_grant(0, LAT + 4, 0, lat);
        check("cont_lat", lat, LAT);
        check("cont_sram0", grant_sram[0], 4);
        check("cont_loser", grant_vld[1], 0);
        pulse_release(16'h0002);
        check("cont_ignored_rel", locked, 32'h0000_0010);
        wait_grant(1, 2 * NS, 0, lat);
        check("cont_no_grant1", lat, -1);
        pulse_release(16'h0001);
        check("cont_released", locked, 0);
        wait_grant(1, 2 * LAT + 4, 0, lat);
        check("cont_grant1", grant_vld[1], 1);
        check("cont_sram1", grant_sram[1], 4);
        pulse_release(16'h0002);

        // Size limit: nothing fits until SRAM 9 reaches the packet length.
        set_all(299, 0);
        do_req(16'h0004, 1, 300, k0);
        wait_grant(2, 3 * LAT, 0, lat);
        check("size_no_grant", lat, -1);
        check("size_locked", locked, 0);
        @(negedge clk);
        fs_m[9] = 300;
        apply_mem();
        wait_grant(2, 2 * LAT + 4, 0, lat);
        check("size_grant", grant_vld[2], 1);
        check("size_sram", grant_sram[2], 9);
        pulse_release(16'h0004);

        // Full flag: all ports lock distinct SRAMs, then starve the remaining ones of space.
        set_all(2047, 0);
        lk_m = '0;
        do_req('1, 3, 10, k0);
        wait_grant(0, LAT + 4, 0, lat);
        check("full_grants", grant_vld, 16'hFFFF);
        for (int p = 0; p < NP; p++) begin
            es = exp_sram(p, k0, 10, '0);
            check($sformatf("full_sram%0d", p), grant_sram[p], es);
            lk_m[es] = 1'b1;
        end
        u = (k0 + NP) % NS;
        @(negedge clk);
        for (int s = 0; s < NS; s++)
            if (!lk_m[s]) fs_m[s] = 100;
        fs_m[u] = 511;
        apply_mem();
        #1;
        check("full_pre", full, 0);
        @(posedge clk); #1;
        check("full_set", full, 16'hFFFF);
        check("full_model", full, exp_full());
        @(negedge clk);
        fs_m[u] = 512;
        apply_mem();
        @(posedge clk); #1;
        check("full_clear", full, 0);
        pulse_release('1);
        lk_m = '0;
        check("full_unlock", locked, 0);

        // Reset while port 5 holds SRAM 8.
        set_all(0, 0);
        fs_m[8] = 2047;
        do_req(16'h0020, 7, 10, k0);
        wait_grant(5, LAT + 4, 0, lat);
        check("rsth_sram", grant_sram[5], 8);
        check("rsth_locked", locked, 32'h0000_0100);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rsth_locked0", locked, 0);
        check("rsth_grant0", grant_vld, 0);
        check("rsth_gsram0", grant_sram != '0, 0);
        @(negedge clk);
        rst = 1'b0;
        run_single("after_rst", 5, 7, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_distributor.md
Name: sram_distributor

Overview:
- Parametrised SRAM-selection engine for the shared-buffer switch.
- Each ingress port that announces a new packet scans every SRAM over a staggered time-division window. It picks the best eligible SRAM, locks that SRAM to itself, and holds the lock until the packet write completes.
- Sits between the port front-ends and the per-SRAM state blocks; replaces the fixed 16×32 hard-wired search in the controller.

Parameters:
- NUM_PORTS, 16: ingress ports. Must be ≤ NUM_SRAMS.
- NUM_SRAMS, 32: SRAM banks.
- SPACE_W, 11: width of free_space and page_amount.
- DEST_W, 4: destination-port field width.
- LEN_W, 9: packet length in pages.
- MIN_SPACE, 512: free-space threshold used by the full flag.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req_vld  in  NUM_PORTS  new packet waiting at port p.
- req_dest  in  NUM_PORTS×DEST_W  destination of the pending packet.
- req_len  in  NUM_PORTS×LEN_W  pages the pending packet needs.
- release  in  NUM_PORTS  one-cycle pulse: port p finished writing, drop its lock.
- free_space  in  NUM_SRAMS×SPACE_W  free pages per SRAM.
- page_amount  in  NUM_SRAMS×SPACE_W  pages held in SRAM s for probe_port[s]. Valid 1 cycle after probe_port.
- probe_port  out  NUM_SRAMS×DEST_W  destination being queried at SRAM s.
- grant_vld  out  NUM_PORTS  one-cycle grant pulse.
- grant_sram  out  NUM_PORTS×clog2(NUM_SRAMS)  granted SRAM index. Held stable until the next grant.
- locked  out  NUM_SRAMS  SRAM currently bound to a port.
- full  out  NUM_PORTS  no SRAM available for new packets.

Behaviour:
- Reset values: grant_vld=0, grant_sram=0, locked=0, probe_port=0, full=0; all port FSMs go to IDLE. A reset mid-scan or mid-hold drops every lock and discards all pending scans.
- Global step counter k (clog2(NUM_SRAMS) bits) free-runs and wraps at NUM_SRAMS−1 to 0.
  - Port p probes SRAM (k+p) mod NUM_SRAMS at step k.
  - The probe mapping is a permutation, so each SRAM is probed by at most one port per cycle.
  - probe_port[s] is registered: the dest of the port probing s in that cycle, or 0 if no port is scanning.
- Per-port FSM states: IDLE, SCAN, GRANT, HOLD.
- IDLE:
  - If req_vld[p]=1, capture req_dest and req_len, clear the best-candidate register, set scan count c=0, and go to SCAN.
  - req_vld is ignored in every other state.
- SCAN (NUM_SRAMS+1 cycles):
  - In cycle c, the SRAM probed in cycle c−1 is evaluated against its returned page_amount.
  - Eligible: locked[s]=0 and free_space[s] ≥ req_len.
  - Ranking: larger page_amount wins, then larger free_space, then earliest probed.
  - After the last evaluation: if a candidate exists go to GRANT, else restart SCAN with c=0.
- GRANT (1 cycle):
  - If the candidate is still unlocked and no lower-index port is granting the same SRAM in this cycle: set locked[s], drive grant_vld[p]=1 and grant_sram[p]=s, and go to HOLD.
  - Otherwise the port loses and restarts SCAN.
- HOLD:
  - On release[p], clear locked[grant_sram[p]] and go to IDLE. A new request can be captured in the following cycle.
  - A release arriving in any state other than HOLD is ignored.
- Same-cycle release and grant on one SRAM: the grant sees the pre-release lock, so the grant is rejected.
- Grant latency: grant_vld rises NUM_SRAMS+2 cycles after req_vld is sampled in IDLE, when uncontended.
- full: every bit is registered and identical, equal to NOT OR over s of (locked[s]=0 AND free_space[s] ≥ MIN_SPACE).
- All comparisons are unsigned. req_len is zero-extended to SPACE_W.

Optional Feature:
- Macro DEST_AFFINITY_EN.
- Defined: page_amount-first ranking as described above.
- Undefined:
  - Ranking uses free_space only; ties go to the earliest probed SRAM.
  - probe_port is tied to 0 and page_amount is unused.
  - The evaluation pipeline stage is removed, so SCAN lasts NUM_SRAMS cycles and grant latency is NUM_SRAMS+1 cycles.

Decomposition:
- Package sram_dist_pkg holds:
  - the port FSM state enum;
  - localparam SRAM_IDX_W = clog2(NUM_SRAMS);
  - a candidate struct {vld, idx, pages, space};
  - function better(a, b), implementing the ranking.
- One sub-module, dist_port_fsm: a per-port scanner and FSM with its candidate register, instantiated NUM_PORTS times.
- The top level keeps the step counter, the lock vector, grant-conflict resolution and the full flag.

Test Plan:
- Single request, defaults: port 3 requests with dest=5, len=10. All free_space=2047, page_amount=0 except SRAM 7 with page_amount=20 → grant_sram[3]=7, grant_vld pulses 34 cycles after req, locked[7]=1.
- Tie-break by space: all page_amount equal, SRAM 12 free_space=900, others 600 → grant 12. Feature off: same result, latency 33.
- Contention: ports 0 and 1 request in the same cycle and only SRAM 4 is eligible → port 0 granted SRAM 4. Port 1 rescans, then gets SRAM 4 only after release[0].
- Size limit: req_len=300, every SRAM free_space=299 → no grant and repeated rescans. Raise SRAM 9 to 300 → grant 9.
- full flag: lock all SRAMs except 2 and set free_space[2]=511 → full=all ones the cycle after the condition. Set free_space[2]=512 → full=0.
- Reset mid-HOLD: port 5 holds SRAM 8, assert rst → locked=0, grant_vld=0. After deassert, a new request on port 5 restarts from IDLE.
